// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM encoding and the
// word-address / byte-offset split of a 32-bit byte address.
package dmem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned NUM_BYTES  = 4;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned WORD_LSB   = BYTE_OFF_W;

  // Misaligned, or word index beyond the stored depth.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
    return (addr[BYTE_OFF_W-1:0] != '0) ||
           ({{BYTE_OFF_W{1'b0}}, addr[31:WORD_LSB]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_bytewrite_ram.sv
// Word-wide storage with per-byte write enables; write and read both registered,
// read data holds until the next read strobe. Contents are never reset.
module dmem_bytewrite_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [NUM_BYTES-1:0] be_i,
  input  logic                 re_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: response WAIT_CYCLES+1 cycles after accept;
// response held until rsp_ready, no new request accepted until then.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        err_q, rd_ok_q;

  logic        accept, go_resp;
  logic        eff_we, eff_err;
  logic [31:0] eff_addr, eff_wdata;
  logic [3:0]  eff_be;
  logic [31:0] ram_rdata;

  assign accept = req_valid && (state_q == ST_IDLE);

  // With zero wait states the commit happens on the accept edge itself,
  // so the live request fields feed the RAM instead of the captured ones.
  assign eff_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign eff_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign eff_be    = (state_q == ST_IDLE) ? req_be    : be_q;
  assign eff_err   = addr_bad(eff_addr, DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (go_resp) begin
        err_q   <= eff_err;
        rd_ok_q <= !eff_we && !eff_err;
      end
    end
  end

  dmem_bytewrite_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (go_resp && eff_we && !eff_err),
    .be_i    (eff_be),
    .re_i    (go_resp && !eff_we && !eff_err),
    .addr_i  (eff_addr[WORD_LSB +: AW]),
    .wdata_i (eff_wdata),
    .rdata_o (ram_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && rd_ok_q) ? ram_rdata : 32'd0;

endmodule
